// File: rtl/uart_tx_mmio_pkg.sv
// rtl/uart_tx_mmio_pkg.sv - register map, status bits and FSM encoding for uart_tx_mmio
package uart_tx_mmio_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// rtl/uart_tx_mmio_fifo.sv - sync_fifo: small synchronous FIFO with zero-latency head word
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok, pop_ok;

  // Pushes while full are dropped here, judged on the pre-edge count.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter on the core load/store port
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0100,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Write_i,
  input  logic        Mem_Read_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic [31:0] Read_Data_o,
  output logic        Tx_o,
  output logic        Busy_o
);

  logic       sel, wr_tx, wr_div, rd_stat;
  logic [1:0] off;
  logic       overflow;
  logic [15:0] baud_div;

  logic       fifo_full, fifo_empty, pop;
  logic [7:0] fifo_head;

  tx_state_e  state, state_nxt;
  logic [7:0]  shift_reg;
  logic [15:0] bit_div, baud_cnt;
  logic [2:0]  bit_idx;
  logic        tx_reg, tx_d, bit_end;

  logic unused_ok;
  assign unused_ok = ^{Address_i[1:0], Write_Data_i[31:16]};

  assign sel     = (Address_i[31:4] == BASE_ADDR[31:4]);
  assign off     = Address_i[3:2];
  assign wr_tx   = Mem_Write_i & sel & (off == REG_TXDATA);
  assign wr_div  = Mem_Write_i & sel & (off == REG_BAUDDIV);
  assign rd_stat = Mem_Read_i  & sel & (off == REG_STATUS);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_tx),
    .push_data (Write_Data_i[7:0]),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A dropped byte and a clearing STATUS read on the same edge leave overflow set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
      baud_div <= DEFAULT_DIV;
    end else begin
      if (wr_tx && fifo_full) overflow <= 1'b1;
      else if (rd_stat)       overflow <= 1'b0;
      if (wr_div) baud_div <= (Write_Data_i[15:0] == 16'd0) ? 16'd1 : Write_Data_i[15:0];
    end
  end

  always_comb begin
    Read_Data_o = 32'd0;
    if (sel) begin
      case (off)
        REG_STATUS: begin
          Read_Data_o[STAT_BUSY]  = (state != ST_IDLE);
          Read_Data_o[STAT_FULL]  = fifo_full;
          Read_Data_o[STAT_EMPTY] = fifo_empty;
          Read_Data_o[STAT_OVF]   = overflow;
        end
        REG_BAUDDIV: Read_Data_o = {16'd0, baud_div};
        default:     Read_Data_o = 32'd0;
      endcase
    end
  end

  assign bit_end = (baud_cnt == bit_div - 16'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      tx_reg    <= 1'b1;
      shift_reg <= 8'd0;
      bit_div   <= DEFAULT_DIV;
      baud_cnt  <= 16'd0;
      bit_idx   <= 3'd0;
    end else begin
      state  <= state_nxt;
      tx_reg <= tx_d;
      if (pop) begin
        shift_reg <= fifo_head;
        bit_div   <= baud_div;
        baud_cnt  <= 16'd0;
        bit_idx   <= 3'd0;
      end else if (state != ST_IDLE) begin
        if (bit_end) begin
          baud_cnt <= 16'd0;
          if (state == ST_DATA) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 3'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + 16'd1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_nxt = ST_START;
      ST_START: if (bit_end) state_nxt = ST_DATA;
      ST_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = ST_STOP;
      ST_STOP:  if (bit_end) state_nxt = fifo_empty ? ST_IDLE : ST_START;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // tx_d is the line level for the cycle after this edge, so it looks at the next state.
  always_comb begin
    pop  = 1'b0;
    tx_d = 1'b1;
    if (!fifo_empty && (state == ST_IDLE || (state == ST_STOP && bit_end))) pop = 1'b1;
    case (state_nxt)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = (state == ST_DATA && bit_end) ? shift_reg[1] : shift_reg[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign Tx_o   = tx_reg;
  assign Busy_o = (state != ST_IDLE) || !fifo_empty;

endmodule
